// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Holds the FSM state enum, the Booth step encoding and the default width.
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Step encoding; ADD/SUB values match the {q[0], q_m1} pair that selects them.
  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit pair.
  function automatic booth_op_e booth_encode(input logic q0, input logic q_m1);
    booth_op_e op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// sign-extended multiplicand into acc, then arithmetic right shift of
// {acc, q, q_m1} by one bit.
// Ports:
//   acc, q, q_m1   current partial-product state
//   m              multiplicand (signed)
//   acc_nxt_c, q_nxt_c, q_m1_nxt_c   state after this iteration
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nxt_c,
  output logic [WIDTH-1:0] q_nxt_c,
  output logic             q_m1_nxt_c
);

  localparam int unsigned ACC_W = WIDTH + 1;

  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] sum;
  booth_op_e        op;

  // One extra sign bit keeps acc - M exact when M is the most negative value.
  assign m_ext = {m[WIDTH-1], m};
  assign op    = booth_encode(q[0], q_m1);

  // Add/subtract selected by the Booth pair
  always_comb begin
    sum = acc;
    case (op)
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
  end

  // Arithmetic shift right of the concatenated {acc, q, q_m1}
  assign acc_nxt_c  = {sum[ACC_W-1], sum[ACC_W-1:1]};
  assign q_nxt_c    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt_c = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed operands. Accepts a/b over a
// valid/ready handshake, iterates WIDTH cycles, and presents a registered
// 2*WIDTH-bit product held until the consumer takes it.
// Optional build macro: BOOTH_ZERO_SKIP_EN -- a zero operand bypasses RUN and
// goes straight to DONE with a zero product.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_ready   operand handshake
//   a, b                 multiplicand / multiplier (signed)
//   out_valid, out_ready product handshake
//   product              signed a*b
//   busy                 high while iterating
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W  = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   m, m_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   q, q_nxt;
  logic               q_m1, q_m1_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PROD_W-1:0]  product_nxt;
  logic               in_ready_nxt;
  logic               out_valid_nxt;
  logic               busy_nxt;

  logic [ACC_W-1:0]   step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               step_q_m1;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc        (acc),
    .q          (q),
    .q_m1       (q_m1),
    .m          (m),
    .acc_nxt_c  (step_acc),
    .q_nxt_c    (step_q),
    .q_m1_nxt_c (step_q_m1)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      m         <= m_nxt;
      acc       <= acc_nxt;
      q         <= q_nxt;
      q_m1      <= q_m1_nxt;
      cnt       <= cnt_nxt;
      product   <= product_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    m_nxt         = m;
    acc_nxt       = acc;
    q_nxt         = q;
    q_m1_nxt      = q_m1;
    cnt_nxt       = cnt;
    product_nxt   = product;
    out_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          m_nxt     = a;
          q_nxt     = b;
          acc_nxt   = '0;
          q_m1_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
`ifdef BOOTH_ZERO_SKIP_EN
          // Clearing q makes {acc, q} zero, so DONE publishes 0 directly.
          if ((a == '0) || (b == '0)) begin
            q_nxt     = '0;
            state_nxt = DONE;
          end
`endif
        end
      end

      RUN: begin
        acc_nxt  = step_acc;
        q_nxt    = step_q;
        q_m1_nxt = step_q_m1;
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end else begin
          out_valid_nxt = 1'b1;
          // acc bit WIDTH is only a guard bit; the exact product fits 2*WIDTH.
          product_nxt   = {acc[WIDTH-1:0], q};
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    in_ready_nxt = (state_nxt == IDLE);
    busy_nxt     = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=32).
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int n_cmp;
  int n_err;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helper: issue one operation, wait for the product, consume it.
  // lat is the number of edges after the accept edge until out_valid, -1 on timeout.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [63:0] p, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    lat      = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    p = product;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #23;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (product !== 64'd0) begin
      n_err++;
      $display("FAIL reset_product: got %h want 0", product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_basic();
    int busy_end;
    int lat;
    logic [63:0] p;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd3;
    b        = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_accept: got in_ready,busy=%b want 01", {in_ready, busy});
    end
    busy_end = -1;
    lat      = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (!busy && busy_end < 0) busy_end = k;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (busy_end !== 32) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d want 32", busy_end);
    end
    n_cmp++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 33", lat);
    end
    p = product;
    n_cmp++;
    if (p !== 64'd15) begin
      n_err++;
      $display("FAIL basic_product: got %h want %h", p, 64'd15);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_return_idle: got %b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_signs();
    logic [63:0] p;
    int lat;
    do_op(-32'sd7, 32'sd6, p, lat);
    n_cmp++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      n_err++;
      $display("FAIL signs_neg_pos: got %h want FFFFFFFFFFFFFFD6", p);
    end
    do_op(-32'sd7, -32'sd6, p, lat);
    n_cmp++;
    if (p !== 64'd42) begin
      n_err++;
      $display("FAIL signs_neg_neg: got %h want %h", p, 64'd42);
    end
    do_op(32'sd1000, -32'sd1, p, lat);
    n_cmp++;
    if (p !== 64'hFFFF_FFFF_FFFF_FC18) begin
      n_err++;
      $display("FAIL signs_pos_neg: got %h want FFFFFFFFFFFFFC18", p);
    end
  endtask

  task automatic test_extreme();
    logic [63:0] p;
    int lat;
    do_op(32'h8000_0000, 32'h8000_0000, p, lat);
    n_cmp++;
    if (p !== 64'h4000_0000_0000_0000) begin
      n_err++;
      $display("FAIL extreme_min_min: got %h want 4000000000000000", p);
    end
    n_cmp++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL extreme_latency: got %0d want 33", lat);
    end
    do_op(32'h8000_0000, 32'h7FFF_FFFF, p, lat);
    n_cmp++;
    if (p !== 64'hC000_0000_8000_0000) begin
      n_err++;
      $display("FAIL extreme_min_max: got %h want C000000080000000", p);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    int lat;
    int bad;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd100;
    b        = -32'sd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want 33", lat);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        a        = 32'd9;
        b        = 32'd9;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          product !== 64'hFFFF_FFFF_FFFF_FED4) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got ov=%b ir=%b p=%h want ov=1 ir=0 p=FFFFFFFFFFFFFED4",
                 k, out_valid, in_ready, product);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got %b want 10", {in_ready, out_valid});
    end
    do_op(32'd9, 32'd9, p, lat);
    n_cmp++;
    if (p !== 64'd81) begin
      n_err++;
      $display("FAIL bp_next_product: got %h want %h", p, 64'd81);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd11;
    b        = 32'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b000 || product !== 64'd0) begin
      n_err++;
      $display("FAIL rstmid_clear: got ov,busy,ir=%b p=%h want 000 p=0",
               {out_valid, busy, in_ready}, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL rstmid_idle: got %b want 100", {in_ready, out_valid, busy});
    end
    do_op(32'd2, 32'd3, p, lat);
    n_cmp++;
    if (p !== 64'd6 || lat !== 33) begin
      n_err++;
      $display("FAIL rstmid_after: got p=%h lat=%0d want p=6 lat=33", p, lat);
    end
  endtask

  task automatic test_zero();
    logic [63:0] p;
    int lat;
    int exp_lat;
`ifdef BOOTH_ZERO_SKIP_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    do_op(32'd0, 32'd123, p, lat);
    n_cmp++;
    if (p !== 64'd0 || lat !== exp_lat) begin
      n_err++;
      $display("FAIL zero_a: got p=%h lat=%0d want p=0 lat=%0d", p, lat, exp_lat);
    end
    do_op(32'd77, 32'd5, p, lat);
    n_cmp++;
    if (p !== 64'd385) begin
      n_err++;
      $display("FAIL zero_nonzero_between: got %h want %h", p, 64'd385);
    end
    do_op(32'd123, 32'd0, p, lat);
    n_cmp++;
    if (p !== 64'd0 || lat !== exp_lat) begin
      n_err++;
      $display("FAIL zero_b: got p=%h lat=%0d want p=0 lat=%0d", p, lat, exp_lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_signs();
    test_extreme();
    test_backpressure();
    test_reset_mid();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
